// File: rtl/ram64_dma.sv
// ram64_dma: block FILL / COPY sequencer for a 64x16 RAM port with an optional SUM operation.
// Define CHECKSUM_EN to build the SUM datapath (op 2); without it op 2 completes immediately like op 3.
module ram64_dma (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [5:0]  src,
  input  logic [5:0]  dst,
  input  logic [6:0]  len,
  input  logic [15:0] fill_val,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic [5:0]  mem_addr,
  output logic [15:0] mem_in,
  output logic        mem_load,
  input  logic [15:0] mem_out
);
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_RD, S_WR, S_SUM, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  src_q, dst_q;
  logic [6:0]  len_q, idx_q;
  logic [15:0] fill_q, hold_q;
  logic        busy_q, done_q;
  logic        accept, last;

  assign accept = (state_q == S_IDLE) && start;
  assign last   = (idx_q == len_q - 7'd1);
  assign busy   = busy_q;
  assign done   = done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == 7'd0) state_d = S_DONE;
          else begin
            case (op)
              2'd0:    state_d = S_FILL;
              2'd1:    state_d = S_RD;
`ifdef CHECKSUM_EN
              2'd2:    state_d = S_SUM;
`endif
              default: state_d = S_DONE;
            endcase
          end
        end
      end
      S_FILL: if (last) state_d = S_DONE;
      S_RD:   state_d = S_WR;
      S_WR:   state_d = last ? S_DONE : S_RD;
`ifdef CHECKSUM_EN
      S_SUM:  if (last) state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM port is decoded from registered state only, so start never reaches it combinationally.
  always_comb begin
    mem_addr = 6'd0;
    mem_in   = 16'd0;
    mem_load = 1'b0;
    case (state_q)
      S_FILL: begin
        mem_addr = dst_q + idx_q[5:0];
        mem_in   = fill_q;
        mem_load = 1'b1;
      end
      S_RD: mem_addr = src_q + idx_q[5:0];
      S_WR: begin
        mem_addr = dst_q + idx_q[5:0];
        mem_in   = hold_q;
        mem_load = 1'b1;
      end
`ifdef CHECKSUM_EN
      S_SUM: mem_addr = src_q + idx_q[5:0];
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      src_q   <= 6'd0;
      dst_q   <= 6'd0;
      len_q   <= 7'd0;
      fill_q  <= 16'd0;
      idx_q   <= 7'd0;
      hold_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      if (accept) begin
        src_q  <= src;
        dst_q  <= dst;
        len_q  <= len;
        fill_q <= fill_val;
        idx_q  <= 7'd0;
      end else if (state_q == S_FILL || state_q == S_WR || state_q == S_SUM) begin
        idx_q <= idx_q + 7'd1;
      end
      if (state_q == S_RD) hold_q <= mem_out;
    end
  end

`ifdef CHECKSUM_EN
  logic [15:0] acc_q, sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 16'd0;
      sum_q <= 16'd0;
    end else if (accept) begin
      acc_q <= 16'd0;
    end else if (state_q == S_SUM) begin
      acc_q <= acc_q + mem_out;
      if (last) sum_q <= acc_q + mem_out;
    end
  end

  assign sum = sum_q;
`else
  assign sum = 16'd0;
`endif

endmodule

// File: doc/ram64_dma.md
# ram64_dma

Sequential initiator for a 64-word × 16-bit RAM port: combinational read of `mem_out` for the currently driven address; write of `mem_in` on the rising `clk` edge when `mem_load` is high. On a start command it autonomously fills, copies, or (optionally) checksums a block of words. It sits between a host or control FSM and the RAM64 array, replacing hand-sequenced address/load driving.

## Interface
- No parameters; data width 16, address width 6, length width 7 are fixed.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: command strobe, sampled only in IDLE.
- `op` input 2: 0 = FILL, 1 = COPY, 2 = SUM (only with `CHECKSUM_EN`), 3 = reserved.
- `src` input 6: source base address (COPY, SUM).
- `dst` input 6: destination base address (FILL, COPY).
- `len` input 7: word count, 0..64.
- `fill_val` input 16: FILL data.
- `busy` output 1: high from the cycle after an accepted start through the DONE state.
- `done` output 1: one-cycle pulse at completion.
- `sum` output 16: checksum result, held until the next SUM completes.
- `mem_addr` output 6: RAM address.
- `mem_in` output 16: RAM write data.
- `mem_load` output 1: RAM write enable.
- `mem_out` input 16: RAM read data, combinational from `mem_addr`.

## Operation
- Command fields (`op`, `src`, `dst`, `len`, `fill_val`) are latched on the accepting edge. Later changes are ignored.
- States: IDLE, FILL, RD, WR, SUM, DONE.
- IDLE, on `start`=1:
  - `len`=0 or `op`=3 goes to DONE.
  - Otherwise FILL (op 0), RD (op 1), or SUM (op 2).
  - Without `CHECKSUM_EN`, op 2 is treated as reserved.
- FILL: drive `mem_addr`=dst+i, `mem_in`=fill_val, `mem_load`=1. Increment i. After word len-1, go to DONE.
- RD: drive `mem_addr`=src+i, `mem_load`=0, capture `mem_out` into a holding register, go to WR.
- WR: drive `mem_addr`=dst+i, `mem_in`=held word, `mem_load`=1. Increment i. Go to RD, or to DONE after word len-1.
- SUM: drive `mem_addr`=src+i and accumulate acc += `mem_out` mod 2^16. After the last word, `sum`←acc and go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Address arithmetic is mod 64: base+i wraps from 63 to 0. `len`=64 covers the whole array.
- Overlapping COPY ranges proceed strictly in ascending i. Forward overlap (dst>src) propagates already-copied data; this is defined behaviour, not an error.
- `start` while busy is ignored. There is no queueing.
- `mem_load` is 0 in IDLE, RD, SUM, and DONE. In idle states `mem_addr`=0 and `mem_in`=0.

## Timing
- Reset (asynchronous, immediate) drives: state IDLE, `busy`=0, `done`=0, `sum`=0, `mem_load`=0, `mem_addr`=0, `mem_in`=0, i=0, acc=0.
- Reset mid-operation aborts the operation. Words already written stay written, and no further `mem_load` is issued.
- Latency from the accepting edge to the `done` pulse:
  - FILL: len+1 cycles.
  - COPY: 2·len+1 cycles.
  - SUM: len+1 cycles.
  - len=0: 1 cycle.
- `busy` and `done` are registered outputs. `mem_*` are registered or decoded from registered state only, with no combinational path from `start`.
- The earliest next `start` is accepted in the cycle after `done`.

## Configuration
- `CHECKSUM_EN` defined: SUM state, accumulator, and `sum` register are built, and op 2 runs SUM.
- `CHECKSUM_EN` undefined:
  - SUM logic is removed.
  - `sum` is tied to 0.
  - op 2 behaves as op 3: immediate DONE with no memory access.

## Test plan
- Reset mid-FILL (rst_n low at word 3 of len=10): outputs return to reset values asynchronously. Only words 0..2 or 0..3 are written, and there is no `done`.
- FILL dst=60, len=8, fill_val=16'hA5A5: addresses 60..63 and 0..3 read A5A5, address 4 is unchanged, and `done` arrives 9 cycles after start.
- COPY src=0, dst=32, len=4 with words 0..3 = 1,2,3,4: words 32..35 = 1,2,3,4, `done` arrives 9 cycles after start, and `mem_load` is high in exactly 4 cycles.
- COPY overlap src=0, dst=1, len=3, word0=7: words 1..3 all = 7.
- len=0 and op=3: `done` arrives 1 cycle after start with zero `mem_load` cycles. A `start` asserted during a busy FILL is ignored.
- With `CHECKSUM_EN`: SUM src=62, len=4 over values 16'hFFFF, 1, 2, 3 gives `sum`=16'h0005. Without the macro, the same command gives `sum`=0 and `done` after 1 cycle.
